rx_slip_ctrl: RTL
=================

RX_SLIP_CTRL -- requirements
Module: rx_slip_ctrl

Interface
REQ-001 SHALL have parameter HDR_WIDTH, default 2, sync header width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, valid header beats masked after each slip (range 1..15).
REQ-003 SHALL have parameter MAX_SLIPS, default 66, slips without lock before sync-fail (range 2..127).
REQ-004 SHALL have port i_clk  input  1  sole clock.
REQ-005 SHALL have port i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_gb_hdr  input  HDR_WIDTH  header from gearbox.
REQ-007 SHALL have port i_gb_hdr_valid  input  1  header qualifier from gearbox.
REQ-008 SHALL have port i_lock_slip  input  1  slip request pulse from lock state machine.
REQ-009 SHALL have port i_block_lock  input  1  block lock status from lock state machine.
REQ-010 SHALL have port o_lock_hdr  output  HDR_WIDTH  header to lock state machine.
REQ-011 SHALL have port o_lock_hdr_valid  output  1  gated header qualifier to lock state machine.
REQ-012 SHALL have port o_gb_slip  output  1  one-cycle slip command to gearbox.
REQ-013 SHALL have port o_slip_cnt  output  7  slips since last lock.
REQ-014 SHALL have port o_sync_fail  output  1  one-cycle pulse when MAX_SLIPS reached.

Function
REQ-015 SHALL implement FSM states HUNT, SLIP, SETTLE, LOCKED; reset state HUNT.
REQ-016 o_lock_hdr/o_lock_hdr_valid SHALL be i_gb_hdr/i_gb_hdr_valid registered, one-cycle latency, in HUNT and LOCKED.
REQ-017 In SLIP and SETTLE, o_lock_hdr_valid SHALL be 0; o_lock_hdr SHALL hold last value.
REQ-018 HUNT: i_lock_slip=1 -> SLIP; else i_block_lock=1 -> LOCKED; else stay.
REQ-019 SLIP SHALL last exactly one cycle, assert o_gb_slip=1, increment o_slip_cnt, then -> SETTLE.
REQ-020 o_gb_slip SHALL rise the cycle after i_lock_slip sampled high; never high two consecutive cycles.
REQ-021 SETTLE SHALL count i_gb_hdr_valid beats; after SETTLE_CYCLES beats -> HUNT; cycles without valid not counted.
REQ-022 i_lock_slip in SLIP or SETTLE SHALL be dropped (no queuing, no count).
REQ-023 LOCKED: o_slip_cnt SHALL clear to 0 on entry; i_lock_slip=1 -> SLIP; else i_block_lock=0 -> HUNT.
REQ-024 i_lock_slip SHALL take priority over i_block_lock in every state.
REQ-025 When increment makes o_slip_cnt equal MAX_SLIPS, o_sync_fail SHALL pulse 1 cycle with o_gb_slip, and o_slip_cnt SHALL wrap to 0 same cycle.
REQ-026 o_slip_cnt SHALL never exceed MAX_SLIPS-1 as observed.

Reset
REQ-027 While i_reset_n=0: state HUNT, o_lock_hdr=0, o_lock_hdr_valid=0, o_gb_slip=0, o_slip_cnt=0, o_sync_fail=0, settle counter 0.
REQ-028 Reset assertion mid-SLIP/SETTLE SHALL abort immediately; first cycle after deassertion behaves as HUNT.

Configuration
REQ-029 Macro RX_SLIP_STATS_EN defined: SHALL add port o_total_slips output 16, saturating count of all o_gb_slip pulses, reset 0, never cleared by lock.
REQ-030 Macro RX_SLIP_STATS_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package rx_slip_pkg SHALL hold state enum rx_slip_state_t and SLIP_CNT_WIDTH=7; HDR_WIDTH default stays a module parameter.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Reset with i_gb_hdr_valid=1, i_gb_hdr=2'b01 -> all outputs 0; first valid passes 1 cycle after deassert.
REQ-034 i_lock_slip pulse in HUNT -> o_gb_slip=1 next cycle, o_slip_cnt=1, next 4 valid beats masked, 5th passes.
REQ-035 Second i_lock_slip during SETTLE -> ignored, o_slip_cnt stays 1, single o_gb_slip pulse.
REQ-036 66 slip requests, no lock -> o_sync_fail=1 coincident with 66th o_gb_slip, o_slip_cnt=0.
REQ-037 3 slips then i_block_lock=1 -> LOCKED, o_slip_cnt=0; i_block_lock=0 -> HUNT, no slip.
REQ-038 i_lock_slip=1 and i_block_lock=1 same cycle in HUNT -> SLIP taken, not LOCKED; with RX_SLIP_STATS_EN, o_total_slips increments.

Source files
------------

// File: rtl/rx_slip_pkg.sv
// Shared types for the receive slip controller: FSM state encoding and slip
// counter width, imported by rx_slip_ctrl.
package rx_slip_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } rx_slip_state_t;

    localparam int SLIP_CNT_WIDTH = 7;

endpackage

// File: rtl/rx_slip_ctrl.sv
// Receive slip controller between the gearbox and the block-lock FSM: issues slips,
// masks headers while the gearbox settles, counts slips and flags sync failure.
// Optional slip statistics port o_total_slips when RX_SLIP_STATS_EN is defined.
module rx_slip_ctrl
    import rx_slip_pkg::*;
#(
    parameter int HDR_WIDTH     = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_SLIPS     = 66
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [HDR_WIDTH-1:0]      i_gb_hdr,
    input  logic                      i_gb_hdr_valid,
    input  logic                      i_lock_slip,
    input  logic                      i_block_lock,
    output logic [HDR_WIDTH-1:0]      o_lock_hdr,
    output logic                      o_lock_hdr_valid,
    output logic                      o_gb_slip,
    output logic [SLIP_CNT_WIDTH-1:0] o_slip_cnt,
    output logic                      o_sync_fail
`ifdef RX_SLIP_STATS_EN
    ,
    output logic [15:0]               o_total_slips
`endif
);

    localparam logic [SLIP_CNT_WIDTH-1:0] SLIP_LIMIT  = SLIP_CNT_WIDTH'(MAX_SLIPS);
    localparam logic [3:0]                SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    rx_slip_state_t            state;
    logic [3:0]                settle_cnt;
    logic [SLIP_CNT_WIDTH-1:0] slip_inc;
    logic                      hdr_pass;

    assign slip_inc = o_slip_cnt + SLIP_CNT_WIDTH'(1);
    assign hdr_pass = (state == ST_HUNT) || (state == ST_LOCKED);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= ST_HUNT;
            settle_cnt       <= '0;
            o_lock_hdr       <= '0;
            o_lock_hdr_valid <= 1'b0;
            o_gb_slip        <= 1'b0;
            o_slip_cnt       <= '0;
            o_sync_fail      <= 1'b0;
        end else begin
            o_gb_slip   <= 1'b0;
            o_sync_fail <= 1'b0;

            // Headers pass only while the gearbox alignment is stable.
            if (hdr_pass) begin
                o_lock_hdr       <= i_gb_hdr;
                o_lock_hdr_valid <= i_gb_hdr_valid;
            end else begin
                o_lock_hdr_valid <= 1'b0;
            end

            case (state)
                ST_HUNT, ST_LOCKED: begin
                    if (i_lock_slip) begin
                        state     <= ST_SLIP;
                        o_gb_slip <= 1'b1;
                        if (slip_inc == SLIP_LIMIT) begin
                            o_slip_cnt  <= '0;
                            o_sync_fail <= 1'b1;
                        end else begin
                            o_slip_cnt <= slip_inc;
                        end
                    end else if ((state == ST_HUNT) && i_block_lock) begin
                        state      <= ST_LOCKED;
                        o_slip_cnt <= '0;
                    end else if ((state == ST_LOCKED) && !i_block_lock) begin
                        state <= ST_HUNT;
                    end
                end
                ST_SLIP: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    // Only qualified beats advance the settle count.
                    if (i_gb_hdr_valid) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= ST_HUNT;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

`ifdef RX_SLIP_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_total_slips <= '0;
        end else if (o_gb_slip) begin
            o_total_slips <= sat_inc16(o_total_slips);
        end
    end
`endif

endmodule
